// File: rtl/mul_seq_pkg.sv
// Shared definitions for the nibble-serial multiply sequencer: FSM states,
// step count, per-step shift amounts and width helpers.
package mul_seq_pkg;

   localparam int DATA_WIDTH = 4;
   localparam int OP_W       = 2 * DATA_WIDTH;
   localparam int PROD_W     = 4 * DATA_WIDTH;
   localparam int NUM_STEPS  = 4;
   localparam int STEP_W     = $clog2(NUM_STEPS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } seq_state_t;

   // Step 0 is the low*low term, steps 1 and 2 are the cross terms
   // (weight 2^N) and step 3 is the high*high term (weight 2^2N).
   function automatic int step_shift(input logic [STEP_W-1:0] step, input int n);
      int sh;
      case (step)
         2'd0:    sh = 0;
         2'd1:    sh = n;
         2'd2:    sh = n;
         default: sh = 2 * n;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/mul8_nibble_sequencer_multiplier.sv
// Shared unsigned N x N multiplier core; purely combinational.
module multiplier #(
   parameter int data_width = 4
) (
   input  logic [data_width-1:0]   a,
   input  logic [data_width-1:0]   b,
   output logic [2*data_width-1:0] p
);

   // Operands are zero-extended so the product is computed at full width.
   assign p = {{data_width{1'b0}}, a} * {{data_width{1'b0}}, b};

endmodule

// File: rtl/mul8_nibble_sequencer.sv
// 2N x 2N multiply sequencer: converts operands to magnitudes, accumulates
// four nibble partial products through one shared core, then restores sign.
module mul8_nibble_sequencer
   import mul_seq_pkg::*;
#(
   parameter int data_width = DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2*data_width-1:0] a,
   input  logic [2*data_width-1:0] b,
   input  logic                    is_signed,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [4*data_width-1:0] product,
   output logic                    busy
);

   localparam int op_w   = 2 * data_width;
   localparam int prod_w = 4 * data_width;

   seq_state_t        state;
   seq_state_t        next_state;
   logic [STEP_W-1:0] step;
   logic [op_w-1:0]   mag_a;
   logic [op_w-1:0]   mag_b;
   logic [op_w-1:0]   a_abs;
   logic [op_w-1:0]   b_abs;
   logic              neg;
   logic [prod_w-1:0] acc;
   logic [prod_w-1:0] pp_shifted;
   logic [data_width-1:0] core_a;
   logic [data_width-1:0] core_b;
   logic [op_w-1:0]   core_p;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // The most negative operand negates to 2^(2N-1), which still fits unsigned.
   assign a_abs = (is_signed && a[op_w-1]) ? (~a + op_w'(1)) : a;
   assign b_abs = (is_signed && b[op_w-1]) ? (~b + op_w'(1)) : b;

   // step[1] picks the high half of a, step[0] the high half of b.
   assign core_a = step[1] ? mag_a[op_w-1 -: data_width] : mag_a[data_width-1:0];
   assign core_b = step[0] ? mag_b[op_w-1 -: data_width] : mag_b[data_width-1:0];

   assign pp_shifted = {{(prod_w-op_w){1'b0}}, core_p} << step_shift(step, data_width);

   multiplier #(.data_width(data_width)) u_core (
      .a (core_a),
      .b (core_b),
      .p (core_p)
   );

   // State register; reset discards any in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic for accept, accumulate, sign fix-up and output hold.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (in_valid) next_state = MUL;
         MUL:  if (step == STEP_W'(NUM_STEPS-1)) next_state = SIGN;
         SIGN: next_state = DONE;
         DONE: if (out_valid && out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath: capture magnitudes, accumulate partial products, publish result.
   always_ff @(posedge clk) begin
      if (rst) begin
         step      <= '0;
         mag_a     <= '0;
         mag_b     <= '0;
         neg       <= 1'b0;
         acc       <= '0;
         product   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mag_a <= a_abs;
                  mag_b <= b_abs;
                  neg   <= is_signed & (a[op_w-1] ^ b[op_w-1]);
                  acc   <= '0;
                  step  <= '0;
               end
            end
            MUL: begin
               acc  <= acc + pp_shifted;
               step <= step + STEP_W'(1);
            end
            SIGN: begin
               product   <= neg ? (~acc + prod_w'(1)) : acc;
               out_valid <= 1'b1;
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul8_nibble_sequencer.sv
// Self-checking bench for mul8_nibble_sequencer: directed corner cases plus
// random transactions compared against an integer-arithmetic reference.
module tb_mul8_nibble_sequencer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        is_signed;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic        busy;

   int n_checks;
   int n_fails;

   mul8_nibble_sequencer #(.data_width(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Product of two 8-bit operands taken as signed or unsigned integers,
   // truncated to 16 bits.
   function automatic logic [15:0] ref_product(input logic [7:0] x, input logic [7:0] y,
                                               input logic s);
      int xi;
      int yi;
      logic [31:0] r;
      xi = s ? int'($signed(x)) : int'({24'b0, x});
      yi = s ? int'($signed(y)) : int'({24'b0, y});
      r  = xi * yi;
      return r[15:0];
   endfunction

   // Count one comparison and report it when it does not hold.
   task automatic check_output(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Run one full transaction: accept, wait for the result, hold it under
   // backpressure for 'hold' cycles (optionally poking in_valid), then accept it.
   task automatic apply_stimulus(input logic [7:0] ta, input logic [7:0] tb_in,
                                 input logic ts, input int hold, input logic poke);
      logic [15:0] exp_p;
      logic [15:0] held;
      int edges;
      exp_p = ref_product(ta, tb_in, ts);
      @(negedge clk);
      check_output("idle_in_ready", in_ready, 1);
      a = ta;
      b = tb_in;
      is_signed = ts;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      edges = 0;
      while (edges < 20 && !out_valid) begin
         @(posedge clk);
         #1 edges++;
      end
      check_output("latency", edges, 5);
      check_output("product", product, exp_p);
      check_output("busy_done", busy, 1);
      held = product;
      for (int i = 0; i < hold; i++) begin
         a = 8'(($urandom & 8'hFF));
         b = 8'(($urandom & 8'hFF));
         in_valid = poke;
         @(negedge clk);
         check_output("hold_product", product, held);
         check_output("hold_valid", out_valid, 1);
         check_output("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check_output("after_hs_valid", out_valid, 0);
      check_output("after_hs_in_ready", in_ready, 1);
      check_output("after_hs_product", product, held);
   endtask

   initial begin
      int seen_out;
      int cyc;
      int n_acc;
      int n_out;
      int acc_cyc [2];
      int out_cyc [2];
      logic [15:0] out_p [2];

      n_checks  = 0;
      n_fails   = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      is_signed = 1'b0;
      out_ready = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_output("rst_out_valid", out_valid, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_in_ready", in_ready, 1);
      check_output("rst_product", product, 0);

      // Directed corner cases.
      apply_stimulus(8'hFF, 8'hFF, 1'b0, 0, 1'b0);
      check_output("ff_ff_unsigned", product, 16'hFE01);
      apply_stimulus(8'h80, 8'h80, 1'b1, 0, 1'b0);
      check_output("m128_sq", product, 16'h4000);
      apply_stimulus(8'h80, 8'h7F, 1'b1, 0, 1'b0);
      check_output("m128_x_127", product, 16'hC080);
      apply_stimulus(8'hFF, 8'h01, 1'b1, 0, 1'b0);
      check_output("m1_x_1", product, 16'hFFFF);
      apply_stimulus(8'hFF, 8'h01, 1'b0, 0, 1'b0);
      check_output("ff_x_1_unsigned", product, 16'h00FF);
      apply_stimulus(8'h00, 8'h85, 1'b1, 0, 1'b0);
      check_output("zero_signed", product, 16'h0000);

      // Backpressure with in_valid asserted while busy; those operands are dropped.
      apply_stimulus(8'h0B, 8'hF3, 1'b1, 10, 1'b1);
      apply_stimulus(8'h03, 8'h05, 1'b0, 0, 1'b0);
      check_output("after_bp_3x5", product, 16'h000F);

      // Reset during the third multiply step discards the transaction.
      @(negedge clk);
      a = 8'h12;
      b = 8'h34;
      is_signed = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check_output("midrst_busy", busy, 0);
      check_output("midrst_out_valid", out_valid, 0);
      check_output("midrst_in_ready", in_ready, 1);
      check_output("midrst_product", product, 0);
      seen_out = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen_out++;
      end
      check_output("midrst_no_output", seen_out, 0);
      apply_stimulus(8'h12, 8'h34, 1'b0, 0, 1'b0);
      check_output("after_rst_12x34", product, 16'h03A8);

      // Back-to-back with in_valid and out_ready held high.
      @(negedge clk);
      a = 8'h07;
      b = 8'h09;
      is_signed = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      cyc = 0;
      n_acc = 0;
      n_out = 0;
      acc_cyc = '{0, 0};
      out_cyc = '{0, 0};
      out_p = '{16'h0, 16'h0};
      for (int k = 0; k < 40; k++) begin
         if (in_valid && in_ready && n_acc < 2) begin
            acc_cyc[n_acc] = cyc + 1;
            n_acc++;
         end
         if (out_valid && n_out < 2) begin
            out_cyc[n_out] = cyc;
            out_p[n_out] = product;
            n_out++;
            if (n_out == 1) begin
               a = 8'hF9;
               b = 8'h09;
            end
         end
         if (n_out == 2) break;
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check_output("b2b_count", n_out, 2);
      check_output("b2b_first", out_p[0], 16'h003F);
      check_output("b2b_second", out_p[1], 16'hFFC1);
      check_output("b2b_lat_first", out_cyc[0] - acc_cyc[0], 5);
      check_output("b2b_lat_second", out_cyc[1] - acc_cyc[1], 5);
      check_output("b2b_reaccept", acc_cyc[1] - out_cyc[0], 2);

      // Random transactions, biased toward the extreme operand values.
      for (int t = 0; t < 40; t++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         ra = 8'($urandom);
         rb = 8'($urandom);
         if ($urandom_range(0, 4) == 0) ra = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h7F;
         if ($urandom_range(0, 4) == 0) rb = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
         apply_stimulus(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                        1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
